logic_eval_filter: RTL and testbench
====================================

LOGIC_EVAL_FILTER -- requirements
Module: logic_eval_filter

Interface
REQ-001 Parameter WIDTH, default 6: number of data inputs evaluated per sample; legal range 2..32.
REQ-002 Parameter STABLE, default 3: number of consecutive valid samples needed to change the filtered output; legal range 1..15.
REQ-003 Parameter CNT_W, default 8: width of the rising-edge event counter.
REQ-004 Port clk, input, 1 bit: the block's only clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: din and mode are sampled in this cycle.
REQ-007 Port din, input, WIDTH bits: input vector to evaluate.
REQ-008 Port mode, input, 2 bits: evaluation function. 00 = AND-reduce, 01 = OR-reduce, 10 = XOR-reduce, 11 = majority.
REQ-009 Port cnt_clr, input, 1 bit: synchronous clear of edge_cnt.
REQ-010 Port raw_y, output, 1 bit: registered, unfiltered function result.
REQ-011 Port raw_valid, output, 1 bit: one-cycle pulse that qualifies raw_y.
REQ-012 Port dout, output, 1 bit: filtered (debounced) result.
REQ-013 Port dout_valid, output, 1 bit: dout holds a qualified value.
REQ-014 Port edge_cnt, output, CNT_W bits: count of dout 0->1 transitions.

Function
REQ-015 Majority is defined as 1 when popcount(din) > WIDTH/2, with integer division; for even WIDTH, a tie gives 0.
REQ-016 Cycle N with in_valid=1: in cycle N+1, raw_y = f(din, mode) and raw_valid = 1.
REQ-017 Cycle N with in_valid=0: raw_valid = 0 in N+1; raw_y holds its previous value.
REQ-018 The filter FSM has three states:
- INIT: no qualified value yet.
- HOLD: dout stable; no candidate pending.
- PEND: a candidate value differing from dout is accumulating consecutive samples.
REQ-019 The FSM advances only on cycles with raw_valid=1; cycles with raw_valid=0 leave state, run count and outputs unchanged.
REQ-020 INIT: the first raw sample becomes the candidate with run = 1.
- Each following equal sample increments run; an unequal sample restarts run at 1 with the new candidate.
- When run reaches STABLE, go to HOLD: dout = candidate, dout_valid = 1, in the same cycle as the STABLE-th raw_valid.
REQ-021 HOLD: a raw sample equal to dout stays in HOLD; an unequal sample goes to PEND with run = 1.
- If STABLE = 1, dout updates immediately and the FSM stays in HOLD.
REQ-022 PEND, sample equal to the candidate: increment run; at STABLE, update dout and go to HOLD.
REQ-022a PEND, sample equal to dout: return to HOLD and discard the run.
REQ-023 A mode value that differs from the mode of the previous valid sample discards any pending run:
- INIT: run restarts at 1 with the new sample.
- PEND: return to HOLD, then evaluate the new sample as in REQ-021.
- dout is not changed by a mode switch.
REQ-024 dout_valid, once set, stays 1 until reset.
REQ-025 edge_cnt increments by 1 in the cycle dout changes from 0 to 1, including the first INIT->HOLD commit to 1. It saturates at 2^CNT_W-1 and never wraps.
REQ-026 If cnt_clr=1, edge_cnt = 0 next cycle. cnt_clr has priority over a simultaneous increment, so that event is not counted.
REQ-027 dout end-to-end latency: STABLE valid samples plus 1 cycle from the first sample of the qualifying run.

Reset
REQ-028 With rst=1 at a clock edge, next cycle:
- raw_y = 0, raw_valid = 0
- dout = 0, dout_valid = 0
- edge_cnt = 0
- FSM = INIT, run = 0, stored mode = 00
REQ-029 rst has priority over in_valid and cnt_clr. Reset mid-PEND discards the run; no dout change and no count.
REQ-030 During rst=1, in_valid is ignored. The first sample after rst deasserts is treated as the first INIT sample.

Verification (WIDTH=6, STABLE=3, CNT_W=8)
REQ-031 Reset, then 3 consecutive valid samples with mode=01, din=6'b000001:
- raw_y = 1 each cycle.
- dout = 1 and dout_valid = 1 on the 3rd raw_valid.
- edge_cnt = 1.
REQ-032 Majority tie, then majority:
- mode=11, din=6'b000111, 3 valid samples: dout = 0, dout_valid = 1.
- Then din=6'b001111, 3 samples: dout = 1, edge_cnt = 1.
REQ-033 From dout=1 with mode=00, valid din sequence 6'h3F, 6'h00, 6'h00, 6'h3F, 6'h00 (glitch):
- dout stays 1 throughout; edge_cnt is unchanged.
REQ-034 Interleaved invalid cycles, from dout=0, mode=10:
- Samples din=6'b000001 with in_valid pattern 1,0,0,1,0,1: dout -> 1 on the 3rd valid sample.
- raw_valid pulses only 3 times.
REQ-035 Mode switch mid-PEND: 2 samples toward 1 under mode=01, then a mode=10 sample giving 1:
- run restarts; dout changes only after 3 mode=10 samples.
REQ-036 Saturation and clear:
- After 255 rising edges, edge_cnt = 255; a further edge keeps it at 255.
- cnt_clr coincident with an edge -> edge_cnt = 0.
- rst asserted mid-PEND -> all outputs 0 next cycle.

Source files
------------

// File: rtl/logic_eval_filter_if.sv
// logic_eval_filter_if: sample/result bundle; master drives in_valid/din/mode/cnt_clr, slave returns raw_y/raw_valid/dout/dout_valid/edge_cnt
interface logic_eval_filter_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] din;
  logic [1:0]       mode;
  logic             cnt_clr;
  logic             raw_y;
  logic             raw_valid;
  logic             dout;
  logic             dout_valid;
  logic [CNT_W-1:0] edge_cnt;
  modport master (
    output in_valid, din, mode, cnt_clr,
    input  raw_y, raw_valid, dout, dout_valid, edge_cnt
  );
  modport slave (
    input  in_valid, din, mode, cnt_clr,
    output raw_y, raw_valid, dout, dout_valid, edge_cnt
  );
endinterface

// File: rtl/logic_eval_filter.sv
// logic_eval_filter: evaluates AND/OR/XOR/majority of din, debounces the result over STABLE samples, counts dout rises (ports: clk, rst, bus slave)
module logic_eval_filter #(
  parameter int WIDTH  = 6,
  parameter int STABLE = 3,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  logic_eval_filter_if.slave bus
);
  localparam int PW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {INIT, HOLD, PEND} state_t;
  state_t           state_q;
  logic [3:0]       run_q, run_d;
  logic [1:0]       mode_q;
  logic             cand_q, raw_y_q, raw_valid_q, dout_q, dout_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    pop;
  logic             y, sw, keep, commit, rise;
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(bus.din[i]);
    y = bus.mode == 2'b00 ? &bus.din :
        bus.mode == 2'b01 ? |bus.din :
        bus.mode == 2'b10 ? ^bus.din : pop > PW'(WIDTH / 2);
  end
  // The FSM works on the combinational result so dout commits on the same edge raw_y is registered.
  assign sw     = bus.mode != mode_q;
  assign run_d  = state_q == INIT ? ((run_q == 4'd0 || sw || y != cand_q) ? 4'd1 : run_q + 4'd1)
                                  : ((state_q == PEND && !sw) ? run_q + 4'd1 : 4'd1);
  assign keep   = state_q != INIT && y == dout_q;
  assign commit = bus.in_valid && !keep && run_d == 4'(STABLE);
  assign rise   = commit && y && !dout_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      run_q        <= '0;
      mode_q       <= '0;
      cand_q       <= 1'b0;
      raw_y_q      <= 1'b0;
      raw_valid_q  <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      raw_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        raw_y_q <= y;
        mode_q  <= bus.mode;
        cand_q  <= y;
        if (keep) begin
          state_q <= HOLD;
          run_q   <= '0;
        end else if (commit) begin
          state_q      <= HOLD;
          run_q        <= '0;
          dout_q       <= y;
          dout_valid_q <= 1'b1;
        end else begin
          state_q <= state_q == INIT ? INIT : PEND;
          run_q   <= run_d;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) cnt_q <= '0;
    else if (rise && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
  assign bus.raw_y      = raw_y_q;
  assign bus.raw_valid  = raw_valid_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.edge_cnt   = cnt_q;
endmodule

// File: tb/tb_logic_eval_filter.sv
// tb_logic_eval_filter: directed checks of evaluation, debounce, mode switch, edge counting and reset
module tb_logic_eval_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic_eval_filter_if #(.WIDTH(6), .CNT_W(8)) bus ();
  logic_eval_filter #(.WIDTH(6), .STABLE(3), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic step(input logic v, input logic [5:0] d, input logic [1:0] m);
    bus.in_valid = v;
    bus.din      = d;
    bus.mode     = m;
    @(posedge clk);
    #1;
    pulses += int'(bus.raw_valid);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic ry, input logic rv, input logic d, input logic dv, input logic [7:0] c);
    chk({tag, ".raw_y"}, 32'(bus.raw_y), 32'(ry));
    chk({tag, ".raw_valid"}, 32'(bus.raw_valid), 32'(rv));
    chk({tag, ".dout"}, 32'(bus.dout), 32'(d));
    chk({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(dv));
    chk({tag, ".edge_cnt"}, 32'(bus.edge_cnt), 32'(c));
  endtask
  initial begin
    bus.cnt_clr = 1'b0;
    step(1'b1, 6'h3F, 2'b01);
    outs("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1, 6'b000001, 2'b01);
    outs("or_s1", 1, 1, 0, 0, 0);
    step(1, 6'b000001, 2'b01);
    outs("or_s2", 1, 1, 0, 0, 0);
    step(1, 6'b000001, 2'b01);
    outs("or_s3", 1, 1, 1, 1, 1);
    step(0, 6'b000000, 2'b01);
    outs("idle_hold", 1, 0, 1, 1, 1);
    step(1, 6'h3F, 2'b00);
    outs("and_g1", 1, 1, 1, 1, 1);
    step(1, 6'h00, 2'b00);
    outs("and_g2", 0, 1, 1, 1, 1);
    step(1, 6'h00, 2'b00);
    outs("and_g3", 0, 1, 1, 1, 1);
    step(1, 6'h3F, 2'b00);
    outs("and_g4", 1, 1, 1, 1, 1);
    step(1, 6'h00, 2'b00);
    outs("and_g5", 0, 1, 1, 1, 1);
    step(1, 6'h00, 2'b00);
    outs("and_f1", 0, 1, 1, 1, 1);
    step(1, 6'h00, 2'b00);
    outs("and_f2", 0, 1, 0, 1, 1);
    pulses = 0;
    step(1, 6'b000001, 2'b10);
    outs("xor_v1", 1, 1, 0, 1, 1);
    step(0, 6'b000001, 2'b10);
    step(0, 6'b000001, 2'b10);
    outs("xor_gap", 1, 0, 0, 1, 1);
    step(1, 6'b000001, 2'b10);
    outs("xor_v2", 1, 1, 0, 1, 1);
    step(0, 6'b000001, 2'b10);
    step(1, 6'b000001, 2'b10);
    outs("xor_v3", 1, 1, 1, 1, 2);
    chk("raw_pulses", 32'(pulses), 32'd3);
    for (int i = 0; i < 3; i++) step(1, 6'b000000, 2'b10);
    outs("xor_low", 0, 1, 0, 1, 2);
    step(1, 6'b000001, 2'b01);
    step(1, 6'b000001, 2'b01);
    outs("sw_or2", 1, 1, 0, 1, 2);
    step(1, 6'b000001, 2'b10);
    outs("sw_x1", 1, 1, 0, 1, 2);
    step(1, 6'b000001, 2'b10);
    outs("sw_x2", 1, 1, 0, 1, 2);
    step(1, 6'b000001, 2'b10);
    outs("sw_x3", 1, 1, 1, 1, 3);
    rst = 1'b1;
    step(1, 6'h3F, 2'b01);
    outs("reset2", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1, 6'b000111, 2'b11);
    step(1, 6'b000111, 2'b11);
    outs("maj_tie2", 0, 1, 0, 0, 0);
    step(1, 6'b000111, 2'b11);
    outs("maj_tie3", 0, 1, 0, 1, 0);
    step(1, 6'b001111, 2'b11);
    step(1, 6'b001111, 2'b11);
    outs("maj_2", 1, 1, 0, 1, 0);
    step(1, 6'b001111, 2'b11);
    outs("maj_3", 1, 1, 1, 1, 1);
    for (int e = 0; e < 254; e++) begin
      for (int k = 0; k < 3; k++) step(1, 6'b000000, 2'b01);
      for (int k = 0; k < 3; k++) step(1, 6'b000001, 2'b01);
    end
    outs("sat_255", 1, 1, 1, 1, 255);
    for (int k = 0; k < 3; k++) step(1, 6'b000000, 2'b01);
    for (int k = 0; k < 3; k++) step(1, 6'b000001, 2'b01);
    outs("sat_hold", 1, 1, 1, 1, 255);
    for (int k = 0; k < 3; k++) step(1, 6'b000000, 2'b01);
    step(1, 6'b000001, 2'b01);
    step(1, 6'b000001, 2'b01);
    bus.cnt_clr = 1'b1;
    step(1, 6'b000001, 2'b01);
    bus.cnt_clr = 1'b0;
    outs("clr_edge", 1, 1, 1, 1, 0);
    step(1, 6'b000000, 2'b01);
    step(1, 6'b000000, 2'b01);
    outs("pend_rst0", 0, 1, 1, 1, 0);
    rst = 1'b1;
    step(1, 6'b000000, 2'b01);
    outs("rst_pend", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 6'b000000, 2'b01);
    outs("post_rst", 0, 0, 0, 0, 0);
    step(1, 6'b000001, 2'b01);
    step(1, 6'b000001, 2'b01);
    outs("init2", 1, 1, 0, 0, 0);
    step(1, 6'b000001, 2'b01);
    outs("init3", 1, 1, 1, 1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
